// File: rtl/rcv_deser.sv
// Serial receive front end: deserialises start/data/parity/stop frames into DATA_W-bit words
// and buffers them, with per-word error flags, in a DEPTH-entry FIFO with a valid/ready head.
module rcv_deser #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rcv_in,
   input  logic                    rcv_bit_en,
   output logic [DATA_W-1:0]       rcv_data,
   output logic                    rcv_par_err,
   output logic                    rcv_frm_err,
   output logic                    rcv_valid,
   input  logic                    rcv_ready,
   output logic [$clog2(DEPTH):0]  rcv_count,
   output logic                    rcv_overrun,
   input  logic                    rcv_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam int unsigned ENT_W = DATA_W + 2;

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic             PAR_ODD  = (PARITY_ODD != 0);
   localparam logic             PAR_EN   = (PARITY_EN != 0);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_PARITY = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
   localparam logic [2:0] ST_BRK    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_err_q, par_err_d;
   logic              push;
   logic [ENT_W-1:0]  push_word;

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ENT_W-1:0]  head_q, head_d;
   logic              overrun_q;
   logic              full, do_pop, do_push, ovr_evt;

   // Frame FSM: every transition is gated by the mid-bit sample strobe.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_err_d = par_err_q;
      push      = 1'b0;
      if (rcv_bit_en) begin
         case (state_q)
            ST_IDLE: begin
               if (!rcv_in) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d[bit_cnt_q] = rcv_in;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = PAR_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
            ST_PARITY: begin
               par_err_d = ((^shift_q) ^ rcv_in) != PAR_ODD;
               state_d   = ST_STOP;
            end
            ST_STOP: begin
               push    = 1'b1;
               state_d = rcv_in ? ST_IDLE : ST_BRK;
            end
            ST_BRK: begin
               if (rcv_in) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign push_word = {shift_q, par_err_q, ~rcv_in};

   assign full    = (count_q == FULL_CNT);
   assign do_pop  = (count_q != '0) && rcv_ready;
   assign do_push = push && (!full || do_pop);
   assign ovr_evt = push && full && !do_pop;

   // Head register tracks the entry at the next read pointer; a push into a queue that will
   // hold only that word is forwarded directly since the memory write lands on the same edge.
   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      head_d   = head_q;
      if (count_d != '0) begin
         if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_word;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         head_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_err_q <= par_err_d;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         if (ovr_evt) begin
            overrun_q <= 1'b1;
         end else if (rcv_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

   assign rcv_data    = head_q[ENT_W-1:2];
   assign rcv_par_err = head_q[1];
   assign rcv_frm_err = head_q[0];
   assign rcv_valid   = (count_q != '0);
   assign rcv_count   = count_q;
   assign rcv_overrun = overrun_q;

endmodule

// File: doc/rcv_deser.md
Name: rcv_deser

Overview:
- Parametrised serial receive front end. Deserialises start/data/parity/stop framed words from a single serial line into DATA_W-bit words and buffers them in a DEPTH-entry FIFO.
- Presents buffered words downstream with a valid/ready handshake.
- Each word carries parity and framing error flags; a sticky overrun flag records dropped words.
- Sits between the line interface and the receive datapath, replacing fixed 8-bit receive paths.

Parameters:
- DATA_W, 8, data bits per frame, range 5..16, sent LSB first.
- DEPTH, 4, FIFO entries, power of 2, minimum 2.
- PARITY_EN, 1, 1 means a parity bit follows the data bits; 0 means no parity bit.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- rcv_in, input, 1, serial line, already synchronised; idles high.
- rcv_bit_en, input, 1, one-cycle strobe at the mid-bit sample point; the line is sampled only on cycles where this is 1.
- rcv_data, output, DATA_W, FIFO head word.
- rcv_par_err, output, 1, parity error flag of the head word.
- rcv_frm_err, output, 1, framing error flag of the head word.
- rcv_valid, output, 1, FIFO non-empty.
- rcv_ready, input, 1, downstream accepts the head word.
- rcv_count, output, $clog2(DEPTH)+1, FIFO occupancy.
- rcv_overrun, output, 1, sticky: a word was dropped because the FIFO was full.
- rcv_clr, input, 1, clears rcv_overrun.

Behaviour:
- Reset: synchronous, active-low, one clock, single clock domain. While rst_n=0 at a clk edge:
  - FSM goes to IDLE and the bit counter and shift register clear.
  - FIFO empties; rcv_valid=0, rcv_count=0, rcv_data=0, rcv_par_err=0, rcv_frm_err=0, rcv_overrun=0.
  - A partially received frame is discarded. A frame already in the FIFO is lost.
- All FSM transitions occur only on cycles with rcv_bit_en=1. All other cycles hold state.
- IDLE:
  - rcv_in=0 goes to DATA with bit counter 0.
  - rcv_in=1 stays in IDLE.
- DATA:
  - Shift rcv_in into bit [count], LSB first.
  - After bit DATA_W-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY:
  - Sample the parity bit.
  - par_err = (^data ^ parbit) != PARITY_ODD.
  - Go to STOP.
- STOP:
  - Sample the stop bit; frm_err = (rcv_in==0).
  - Push {data, par_err, frm_err} to the FIFO.
  - Go to IDLE if rcv_in=1, or to BRK if rcv_in=0.
- BRK:
  - Stay until a rcv_bit_en sample with rcv_in=1, then go to IDLE.
  - This prevents a break or low line being taken as back-to-back start bits.
- Words with errors are still pushed; the flags travel with the data. par_err=0 when PARITY_EN=0.
- Push latency: the pushed word is visible at the FIFO head with rcv_valid=1 on the cycle after the STOP-sample edge, if the FIFO was empty.
- Pop: occurs on any cycle with rcv_valid=1 and rcv_ready=1. The head advances at that edge. rcv_ready while rcv_valid=0 has no effect.
- Outputs: rcv_data, rcv_par_err and rcv_frm_err are registered FIFO head values. They are held stable while rcv_valid=1 and rcv_ready=0. When empty they hold the last value (don't-care).
- Full with no pop in the same cycle: the push is dropped, rcv_overrun sets, and FIFO contents are unchanged.
- Full with a pop in the same cycle: the push is accepted, rcv_count stays DEPTH, and no overrun occurs.
- Empty: a push and rcv_ready=1 in the same cycle means no pop occurs (rcv_valid was 0). The word appears on the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. rcv_count ranges 0..DEPTH.
- rcv_clr=1 clears rcv_overrun. If an overrun event occurs in the same cycle, set wins.

Test Plan:
- Reset mid-frame: send start and 3 data bits, pulse rst_n=0 for 1 clk, then send a clean frame of 0xA5 (even parity bit 0, stop 1). Required: exactly one word, rcv_data=0xA5, both flags 0, rcv_count=1.
- Parity: PARITY_ODD=0, send 0x07 with parity bit 0. Required: rcv_par_err=1, rcv_frm_err=0. Then send 0x07 with parity bit 1. Required: rcv_par_err=0.
- Framing/break: send 0x3C with stop bit 0, then hold the line low for 12 bit_en strobes, then high. Required: one word with rcv_frm_err=1, and no further words until a new start bit follows a high sample.
- Overrun: DEPTH=4, rcv_ready=0, send 5 frames 0x01..0x05. Required: rcv_count=4, rcv_overrun=1, pops return 0x01..0x04. Then pulse rcv_clr. Required: rcv_overrun=0.
- Full plus simultaneous pop: fill 4 entries, assert rcv_ready for exactly the cycle of the 5th push. Required: rcv_count stays 4, rcv_overrun=0, drain returns 0x02..0x05 (pointer wrap verified).
- Backpressure stability: toggle rcv_ready randomly across 20 frames. Required: in-order delivery, head outputs stable while valid and not ready, rcv_count consistent with pushes minus pops every cycle.
